// File: rtl/regfile.sv
// Purpose : architectural integer register file at the MEM/WB write-back point, with
//           two decode read ports, a debug read port and a per-register busy scoreboard.
// Latency : reads are combinational; a write-back is bypassed to readers in the same cycle
//           and comes from storage from the following cycle.
// Backpressure: none; the scoreboard busy flags are what decode uses to stall.
//
// Ports
//   clk_in, reset_in                 clock / asynchronous active-low reset
//   reg_wdata_in/waddr_in/we_in      registered write-back from MEM/WB
//   re{1,2}_in, raddr{1,2}_in        decode read ports -> rdata{1,2}_out, busy{1,2}_out
//   set_busy_in, set_addr_in         decode marks a destination as in flight
//   dbg_raddr_in                     debug read index -> dbg_rdata_out
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [DATA_W-1:0] reg_wdata_in,
  input  logic [ADDR_W-1:0] reg_waddr_in,
  input  logic              reg_we_in,
  input  logic              re1_in,
  input  logic [ADDR_W-1:0] raddr1_in,
  output logic [DATA_W-1:0] rdata1_out,
  output logic              busy1_out,
  input  logic              re2_in,
  input  logic [ADDR_W-1:0] raddr2_in,
  output logic [DATA_W-1:0] rdata2_out,
  output logic              busy2_out,
  input  logic              set_busy_in,
  input  logic [ADDR_W-1:0] set_addr_in,
  input  logic [ADDR_W-1:0] dbg_raddr_in,
  output logic [DATA_W-1:0] dbg_rdata_out
);

  localparam int              NREG         = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] ZERO        = '0;
  localparam logic [ADDR_W-1:0] ZERO_REG    = '0;
  localparam logic              WRITE_ENABLE = 1'b1;

  logic [DATA_W-1:0] mem_q [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;

  // A write-back is only live while out of reset; gating here keeps the bypass from
  // leaking write data onto the read ports while reset is held.
  logic wb_live;
  logic wr_take;

  assign wb_live = reset_in && (reg_we_in == WRITE_ENABLE);
  assign wr_take = wb_live && (reg_waddr_in != ZERO_REG);

  // Scoreboard next state: clear on write-back, then set on issue so that a newer issue
  // to the same register wins over the retiring older write.
  always_comb begin
    busy_d = busy_q;
    if (reg_we_in == WRITE_ENABLE) begin
      busy_d[reg_waddr_in] = 1'b0;
    end
    if (set_busy_in) begin
      busy_d[set_addr_in] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= ZERO;
      end
      busy_q <= '0;
    end else begin
      if (wr_take) begin
        mem_q[reg_waddr_in] <= reg_wdata_in;
      end
      busy_q <= busy_d;
    end
  end

  // Common read rule shared by all three ports; stored_val is mem_q[addr] supplied by
  // the caller so every dependency is visible to the enclosing always_comb.
  function automatic logic [DATA_W-1:0] read_port(
    input logic              re,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored_val
  );
    if (!re || addr == ZERO_REG) begin
      return ZERO;
    end else if (wb_live && reg_waddr_in == addr) begin
      return reg_wdata_in;
    end else begin
      return stored_val;
    end
  endfunction

  always_comb begin
    rdata1_out    = read_port(re1_in, raddr1_in, mem_q[raddr1_in]);
    rdata2_out    = read_port(re2_in, raddr2_in, mem_q[raddr2_in]);
    dbg_rdata_out = read_port(1'b1, dbg_raddr_in, mem_q[dbg_raddr_in]);
  end

  // A same-cycle write-back to the read index hides the busy bit: its data is bypassed.
  always_comb begin
    busy1_out = re1_in && busy_q[raddr1_in] && !(wb_live && reg_waddr_in == raddr1_in);
    busy2_out = re2_in && busy_q[raddr2_in] && !(wb_live && reg_waddr_in == raddr2_in);
  end

endmodule
